// File: rtl/cache_controller.sv
// Set-associative cache controller: tag lookup, LRU update, dirty write-back, line fill and
// allocation against an external tag memory and a line-granular backing memory.
module cache_controller #(
  parameter int unsigned TAG_WIDTH    = 8,
  parameter int unsigned INDEX_WIDTH  = 4,
  parameter int unsigned OFFSET_WIDTH = 4,
  parameter int unsigned CHAN_WIDTH   = 3
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    cpu_req,
  input  logic                                    cpu_we,
  input  logic [TAG_WIDTH+INDEX_WIDTH+OFFSET_WIDTH-1:0] cpu_addr,
  output logic                                    cpu_ack,
  output logic                                    cpu_busy,
  output logic [TAG_WIDTH-1:0]                    tm_tag,
  output logic [INDEX_WIDTH-1:0]                  tm_index,
  output logic                                    tm_wr,
  output logic                                    tm_mod,
  output logic                                    tm_age,
  input  logic                                    tm_hit,
  input  logic [CHAN_WIDTH-1:0]                   tm_chan,
  input  logic [CHAN_WIDTH-1:0]                   tm_age_chan,
  input  logic [TAG_WIDTH-1:0]                    tm_age_tag,
  input  logic                                    tm_age_mod,
  output logic [CHAN_WIDTH-1:0]                   line_chan,
  output logic                                    mem_req,
  output logic                                    mem_we,
  output logic [TAG_WIDTH+INDEX_WIDTH-1:0]        mem_addr,
  input  logic                                    mem_ack,
  output logic [15:0]                             hit_cnt,
  output logic [15:0]                             miss_cnt,
  output logic                                    err
);

  localparam int unsigned AddrWidth = TAG_WIDTH + INDEX_WIDTH + OFFSET_WIDTH;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StLookup = 3'd1;
  localparam logic [2:0] StHitUpd = 3'd2;
  localparam logic [2:0] StWb     = 3'd3;
  localparam logic [2:0] StFill   = 3'd4;
  localparam logic [2:0] StAlloc  = 3'd5;
  localparam logic [2:0] StDone   = 3'd6;

  logic [2:0]             state_q, state_d;
  logic [TAG_WIDTH-1:0]   tag_q, tag_d;
  logic [INDEX_WIDTH-1:0] index_q, index_d;
  logic                   we_q, we_d;
  logic                   first_q, first_d;
  logic [TAG_WIDTH-1:0]   victim_tag_q, victim_tag_d;
  logic [CHAN_WIDTH-1:0]  line_chan_q, line_chan_d;
  logic [15:0]            hit_cnt_q, hit_cnt_d;
  logic [15:0]            miss_cnt_q, miss_cnt_d;
  logic                   err_q, err_d;

  // The byte offset never reaches the controller's datapath.
  logic unused_offset;
  assign unused_offset = ^cpu_addr[OFFSET_WIDTH-1:0];

  always_comb begin
    state_d      = state_q;
    tag_d        = tag_q;
    index_d      = index_q;
    we_d         = we_q;
    first_d      = first_q;
    victim_tag_d = victim_tag_q;
    line_chan_d  = line_chan_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    err_d        = err_q;
    unique case (state_q)
      StIdle: begin
        if (cpu_req) begin
          tag_d   = cpu_addr[AddrWidth-1 -: TAG_WIDTH];
          index_d = cpu_addr[OFFSET_WIDTH +: INDEX_WIDTH];
          we_d    = cpu_we;
          first_d = 1'b1;
          state_d = StLookup;
        end
      end
      StLookup: begin
        first_d = 1'b0;
        if (tm_hit) begin
          line_chan_d = tm_chan;
          state_d     = StHitUpd;
          if (first_q && hit_cnt_q != 16'hFFFF) hit_cnt_d = hit_cnt_q + 16'd1;
        end else if (!first_q) begin
          // The line was just allocated, so a miss here means the tag memory misbehaved.
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          line_chan_d = tm_age_chan;
          if (miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
          if (tm_age_mod) begin
            victim_tag_d = tm_age_tag;
            state_d      = StWb;
          end else begin
            state_d = StFill;
          end
        end
      end
      StHitUpd: state_d = StDone;
      StWb:     if (mem_ack) state_d = StFill;
      StFill:   if (mem_ack) state_d = StAlloc;
      StAlloc:  state_d = StLookup;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      tag_q        <= '0;
      index_q      <= '0;
      we_q         <= 1'b0;
      first_q      <= 1'b0;
      victim_tag_q <= '0;
      line_chan_q  <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      tag_q        <= tag_d;
      index_q      <= index_d;
      we_q         <= we_d;
      first_q      <= first_d;
      victim_tag_q <= victim_tag_d;
      line_chan_q  <= line_chan_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    cpu_busy  = (state_q != StIdle);
    cpu_ack   = (state_q == StDone);
    tm_age    = (state_q == StHitUpd);
    tm_mod    = (state_q == StHitUpd) && we_q;
    tm_wr     = ((state_q == StHitUpd) && we_q) || (state_q == StAlloc);
    mem_req   = (state_q == StWb) || (state_q == StFill);
    mem_we    = (state_q == StWb);
    mem_addr  = '0;
    if (state_q == StWb)   mem_addr = {victim_tag_q, index_q};
    if (state_q == StFill) mem_addr = {tag_q, index_q};
    tm_tag    = tag_q;
    tm_index  = index_q;
    line_chan = line_chan_q;
    hit_cnt   = hit_cnt_q;
    miss_cnt  = miss_cnt_q;
    err       = err_q;
  end

endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench for cache_controller: a reactive tag/backing memory model drives each
// transaction, expected records are queued at stimulus time and popped at cpu_ack.
module tb_cache_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we;
  logic [15:0] cpu_addr;
  logic        cpu_ack, cpu_busy;
  logic [7:0]  tm_tag;
  logic [3:0]  tm_index;
  logic        tm_wr, tm_mod, tm_age, tm_hit;
  logic [2:0]  tm_chan, tm_age_chan, line_chan;
  logic [7:0]  tm_age_tag;
  logic        tm_age_mod;
  logic        mem_req, mem_we, mem_ack;
  logic [11:0] mem_addr;
  logic [15:0] hit_cnt, miss_cnt;
  logic        err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int lat; int hit_cnt; int miss_cnt; int err;
    int age_n; int wr_n; int mod_n;
    int wb_addr; int fill_addr; int fill_chan; int hit_chan;
    int tag; int idx; int ack_after; int busy_after; int stable_bad;
  } rec_t;

  rec_t exp_q[$];

  cache_controller dut (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_ack(cpu_ack), .cpu_busy(cpu_busy), .tm_tag(tm_tag), .tm_index(tm_index),
    .tm_wr(tm_wr), .tm_mod(tm_mod), .tm_age(tm_age), .tm_hit(tm_hit), .tm_chan(tm_chan),
    .tm_age_chan(tm_age_chan), .tm_age_tag(tm_age_tag), .tm_age_mod(tm_age_mod),
    .line_chan(line_chan), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .err(err)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0;
    tm_hit = 1'b0; tm_chan = '0; tm_age_chan = '0; tm_age_tag = '0; tm_age_mod = 1'b0;
    mem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drives one request from a negedge and plays tag memory and backing memory until cpu_ack.
  task automatic run_txn(input logic [15:0] addr, input logic we, input logic hit,
                         input int chan, input int age_chan, input int age_tag,
                         input logic age_mod, input int wb_delay, input int fill_delay,
                         input logic force_miss, input logic hold_req, output rec_t o);
    int mem_cnt;
    int addr_first;
    logic done;
    o = '{default: 0};
    o.lat = -1;
    mem_cnt = 0; addr_first = -1; done = 1'b0;
    tm_hit = hit; tm_chan = 3'(chan); tm_age_chan = 3'(age_chan);
    tm_age_tag = 8'(age_tag); tm_age_mod = age_mod;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr;
    for (int cyc = 1; cyc <= 200 && !done; cyc++) begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (hold_req) begin
        cpu_addr = ~addr; cpu_we = ~we;
      end else begin
        cpu_req = 1'b0;
      end
      if (tm_age) begin
        o.age_n++; o.hit_chan = int'(line_chan);
      end
      if (tm_wr) begin
        o.wr_n++;
        if (tm_mod) o.mod_n++;
        if (!tm_age && !force_miss) begin
          tm_hit = 1'b1; tm_chan = 3'(age_chan);
        end
      end
      if (mem_req) begin
        if (addr_first < 0) addr_first = int'(mem_addr);
        else if (int'(mem_addr) != addr_first) o.stable_bad++;
        if (mem_we) o.wb_addr = int'(mem_addr);
        else begin
          o.fill_addr = int'(mem_addr); o.fill_chan = int'(line_chan);
        end
        mem_cnt++;
        if (mem_cnt == (mem_we ? wb_delay : fill_delay)) begin
          mem_ack = 1'b1; mem_cnt = 0; addr_first = -1;
        end
      end
      if (cpu_ack) begin
        o.lat = cyc; o.hit_cnt = int'(hit_cnt); o.miss_cnt = int'(miss_cnt);
        o.err = int'(err); o.tag = int'(tm_tag); o.idx = int'(tm_index);
        cpu_req = 1'b0; done = 1'b1;
      end
    end
    @(negedge clk);
    mem_ack = 1'b0;
    o.ack_after = int'(cpu_ack); o.busy_after = int'(cpu_busy);
  endtask

  task automatic test_reset();
    rec_t o;
    do_reset();
    run_txn(16'h5A31, 1'b1, 1'b1, 6, 0, 0, 1'b0, 1, 1, 1'b0, 1'b0, o);
    do_reset();
    @(negedge clk);
    checks++;
    if ({cpu_ack, cpu_busy, tm_wr, tm_mod, tm_age, mem_req, mem_we, err} !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 00000000",
               {cpu_ack, cpu_busy, tm_wr, tm_mod, tm_age, mem_req, mem_we, err});
    end
    checks++;
    if ({hit_cnt, miss_cnt} !== 32'h0) begin
      errors++; $display("FAIL reset_counters: got %h required 0", {hit_cnt, miss_cnt});
    end
    checks++;
    if ({tm_tag, tm_index, line_chan, mem_addr} !== 27'h0) begin
      errors++;
      $display("FAIL reset_latched: got %h required 0", {tm_tag, tm_index, line_chan, mem_addr});
    end
  endtask

  task automatic test_read_hit();
    rec_t o, e;
    do_reset();
    e = '{default: 0};
    e.lat = 3; e.hit_cnt = 1; e.age_n = 1; e.hit_chan = 5; e.tag = 'h3A; e.idx = 7;
    exp_q.push_back(e);
    run_txn(16'h3A7C, 1'b0, 1'b1, 5, 0, 0, 1'b0, 1, 1, 1'b0, 1'b0, o);
    e = exp_q.pop_front();
    checks++;
    if (o.lat !== e.lat) begin errors++; $display("FAIL hit_latency: got %0d required %0d", o.lat, e.lat); end
    checks++;
    if (o.tag !== e.tag || o.idx !== e.idx) begin
      errors++; $display("FAIL hit_tag_index: got %h/%h required %h/%h", o.tag, o.idx, e.tag, e.idx);
    end
    checks++;
    if (o.age_n !== e.age_n || o.wr_n !== e.wr_n || o.hit_chan !== e.hit_chan) begin
      errors++;
      $display("FAIL hit_tm_strobes: got age=%0d wr=%0d chan=%0d required age=%0d wr=%0d chan=%0d",
               o.age_n, o.wr_n, o.hit_chan, e.age_n, e.wr_n, e.hit_chan);
    end
    checks++;
    if (o.hit_cnt !== e.hit_cnt || o.miss_cnt !== e.miss_cnt) begin
      errors++; $display("FAIL hit_counts: got %0d/%0d required %0d/%0d",
                         o.hit_cnt, o.miss_cnt, e.hit_cnt, e.miss_cnt);
    end
    checks++;
    if (o.ack_after !== 0 || o.busy_after !== 0) begin
      errors++; $display("FAIL hit_ack_single: got ack=%0d busy=%0d required 0/0", o.ack_after, o.busy_after);
    end
  endtask

  task automatic test_clean_miss();
    rec_t o, e;
    do_reset();
    e = '{default: 0};
    e.lat = 9; e.miss_cnt = 1; e.age_n = 1; e.wr_n = 1; e.fill_addr = 'h3A7; e.fill_chan = 2;
    e.hit_chan = 2;
    exp_q.push_back(e);
    run_txn(16'h3A7C, 1'b0, 1'b0, 0, 2, 'h55, 1'b0, 1, 4, 1'b0, 1'b0, o);
    e = exp_q.pop_front();
    checks++;
    if (o.lat !== e.lat) begin errors++; $display("FAIL clean_latency: got %0d required %0d", o.lat, e.lat); end
    checks++;
    if (o.fill_addr !== e.fill_addr || o.fill_chan !== e.fill_chan || o.wb_addr !== e.wb_addr) begin
      errors++; $display("FAIL clean_mem: got fill=%h chan=%0d wb=%h required fill=%h chan=%0d wb=%h",
                         o.fill_addr, o.fill_chan, o.wb_addr, e.fill_addr, e.fill_chan, e.wb_addr);
    end
    checks++;
    if (o.wr_n !== e.wr_n || o.mod_n !== e.mod_n || o.age_n !== e.age_n || o.hit_chan !== e.hit_chan) begin
      errors++; $display("FAIL clean_tm: got wr=%0d mod=%0d age=%0d chan=%0d required %0d/%0d/%0d/%0d",
                         o.wr_n, o.mod_n, o.age_n, o.hit_chan, e.wr_n, e.mod_n, e.age_n, e.hit_chan);
    end
    checks++;
    if (o.hit_cnt !== e.hit_cnt || o.miss_cnt !== e.miss_cnt || o.stable_bad !== 0) begin
      errors++; $display("FAIL clean_counts: got %0d/%0d unstable=%0d required %0d/%0d/0",
                         o.hit_cnt, o.miss_cnt, o.stable_bad, e.hit_cnt, e.miss_cnt);
    end
  endtask

  task automatic test_dirty_write_miss();
    rec_t o, e;
    do_reset();
    e = '{default: 0};
    e.lat = 10; e.miss_cnt = 1; e.age_n = 1; e.wr_n = 2; e.mod_n = 1; e.wb_addr = 'h117;
    e.fill_addr = 'h3A7; e.fill_chan = 4; e.hit_chan = 4;
    exp_q.push_back(e);
    run_txn(16'h3A7C, 1'b1, 1'b0, 0, 4, 'h11, 1'b1, 2, 3, 1'b0, 1'b0, o);
    e = exp_q.pop_front();
    checks++;
    if (o.lat !== e.lat) begin errors++; $display("FAIL dirty_latency: got %0d required %0d", o.lat, e.lat); end
    checks++;
    if (o.wb_addr !== e.wb_addr || o.fill_addr !== e.fill_addr || o.fill_chan !== e.fill_chan) begin
      errors++; $display("FAIL dirty_mem: got wb=%h fill=%h chan=%0d required wb=%h fill=%h chan=%0d",
                         o.wb_addr, o.fill_addr, o.fill_chan, e.wb_addr, e.fill_addr, e.fill_chan);
    end
    checks++;
    if (o.wr_n !== e.wr_n || o.mod_n !== e.mod_n || o.age_n !== e.age_n || o.stable_bad !== 0) begin
      errors++; $display("FAIL dirty_tm: got wr=%0d mod=%0d age=%0d unstable=%0d required %0d/%0d/%0d/0",
                         o.wr_n, o.mod_n, o.age_n, o.stable_bad, e.wr_n, e.mod_n, e.age_n);
    end
    checks++;
    if (o.miss_cnt !== e.miss_cnt || o.hit_cnt !== e.hit_cnt) begin
      errors++; $display("FAIL dirty_counts: got %0d/%0d required %0d/%0d",
                         o.hit_cnt, o.miss_cnt, e.hit_cnt, e.miss_cnt);
    end
  endtask

  task automatic test_fast_mem_ack();
    rec_t o, e;
    do_reset();
    e = '{default: 0};
    e.lat = 7; e.miss_cnt = 1; e.wr_n = 1; e.age_n = 1;
    exp_q.push_back(e);
    run_txn(16'hC4F0, 1'b0, 1'b0, 0, 7, 'h9C, 1'b1, 1, 1, 1'b0, 1'b0, o);
    e = exp_q.pop_front();
    checks++;
    if (o.lat !== e.lat || o.wr_n !== e.wr_n || o.age_n !== e.age_n) begin
      errors++; $display("FAIL fast_ack: got lat=%0d wr=%0d age=%0d required %0d/%0d/%0d",
                         o.lat, o.wr_n, o.age_n, e.lat, e.wr_n, e.age_n);
    end
  endtask

  task automatic test_saturation();
    rec_t o, e;
    do_reset();
    force dut.hit_cnt_q = 16'hFFFE;
    @(negedge clk);
    release dut.hit_cnt_q;
    for (int i = 0; i < 2; i++) begin
      e = '{default: 0};
      e.hit_cnt = 'hFFFF;
      exp_q.push_back(e);
      run_txn(16'h1230, 1'b0, 1'b1, 1, 0, 0, 1'b0, 1, 1, 1'b0, 1'b0, o);
      e = exp_q.pop_front();
      checks++;
      if (o.hit_cnt !== e.hit_cnt || o.miss_cnt !== e.miss_cnt) begin
        errors++; $display("FAIL sat_hit_cnt: got %h/%h required %h/%h",
                           o.hit_cnt, o.miss_cnt, e.hit_cnt, e.miss_cnt);
      end
    end
  endtask

  task automatic test_reset_during_fill();
    int bad;
    rec_t o, e;
    do_reset();
    tm_hit = 1'b0; tm_age_chan = 3'd3; tm_age_mod = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h3A7C;
    @(negedge clk);
    cpu_req = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0) begin
      errors++; $display("FAIL abort_in_fill: got req=%b we=%b required 1/0", mem_req, mem_we);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if ({mem_req, cpu_busy, cpu_ack, tm_wr} !== 4'b0000) begin
      errors++; $display("FAIL abort_outputs: got %b required 0000", {mem_req, cpu_busy, cpu_ack, tm_wr});
    end
    bad = 0;
    mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (cpu_busy !== 1'b0 || mem_req !== 1'b0 || cpu_ack !== 1'b0 || tm_wr !== 1'b0) bad++;
    end
    mem_ack = 1'b0;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL spurious_mem_ack: got %0d bad cycles required 0", bad); end
    e = '{default: 0};
    e.lat = 3; e.hit_cnt = 1;
    exp_q.push_back(e);
    run_txn(16'h3A7C, 1'b0, 1'b1, 3, 0, 0, 1'b0, 1, 1, 1'b0, 1'b0, o);
    e = exp_q.pop_front();
    checks++;
    if (o.lat !== e.lat || o.hit_cnt !== e.hit_cnt) begin
      errors++; $display("FAIL abort_recover: got lat=%0d hits=%0d required %0d/%0d",
                         o.lat, o.hit_cnt, e.lat, e.hit_cnt);
    end
  endtask

  task automatic test_relookup_error();
    rec_t o, e;
    do_reset();
    e = '{default: 0};
    e.lat = 6; e.miss_cnt = 1; e.err = 1; e.wr_n = 1;
    exp_q.push_back(e);
    run_txn(16'h8E20, 1'b0, 1'b0, 0, 1, 0, 1'b0, 1, 2, 1'b1, 1'b0, o);
    e = exp_q.pop_front();
    checks++;
    if (o.lat !== e.lat || o.err !== e.err || o.age_n !== e.age_n || o.wr_n !== e.wr_n) begin
      errors++; $display("FAIL relookup_err: got lat=%0d err=%0d age=%0d wr=%0d required %0d/%0d/%0d/%0d",
                         o.lat, o.err, o.age_n, o.wr_n, e.lat, e.err, e.age_n, e.wr_n);
    end
    e = '{default: 0};
    e.lat = 3; e.miss_cnt = 1; e.hit_cnt = 1; e.err = 1;
    exp_q.push_back(e);
    run_txn(16'h8E20, 1'b0, 1'b1, 1, 0, 0, 1'b0, 1, 1, 1'b0, 1'b0, o);
    e = exp_q.pop_front();
    checks++;
    if (o.err !== e.err || o.lat !== e.lat || o.hit_cnt !== e.hit_cnt) begin
      errors++; $display("FAIL err_sticky: got err=%0d lat=%0d hits=%0d required %0d/%0d/%0d",
                         o.err, o.lat, o.hit_cnt, e.err, e.lat, e.hit_cnt);
    end
    do_reset();
    @(negedge clk);
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL err_cleared: got %b required 0", err); end
  endtask

  task automatic test_back_to_back();
    rec_t o, e;
    logic [15:0] addrs [3];
    int chans [3];
    addrs[0] = 16'hB2D7; addrs[1] = 16'h04F1; addrs[2] = 16'hFFEE;
    chans[0] = 7; chans[1] = 0; chans[2] = 3;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      e = '{default: 0};
      e.lat = 3; e.hit_cnt = i + 1; e.hit_chan = chans[i];
      e.tag = int'(addrs[i][15:8]); e.idx = int'(addrs[i][7:4]);
      e.wr_n = (i == 1) ? 1 : 0; e.mod_n = e.wr_n; e.age_n = 1;
      exp_q.push_back(e);
      run_txn(addrs[i], (i == 1), 1'b1, chans[i], 0, 0, 1'b0, 1, 1, 1'b0, (i != 2), o);
      e = exp_q.pop_front();
      checks++;
      if (o.lat !== e.lat || o.tag !== e.tag || o.idx !== e.idx || o.hit_chan !== e.hit_chan) begin
        errors++; $display("FAIL b2b_latched[%0d]: got lat=%0d %h/%h chan=%0d required %0d %h/%h chan=%0d",
                           i, o.lat, o.tag, o.idx, o.hit_chan, e.lat, e.tag, e.idx, e.hit_chan);
      end
      checks++;
      if (o.hit_cnt !== e.hit_cnt || o.wr_n !== e.wr_n || o.mod_n !== e.mod_n || o.age_n !== e.age_n) begin
        errors++; $display("FAIL b2b_effects[%0d]: got hits=%0d wr=%0d mod=%0d age=%0d required %0d/%0d/%0d/%0d",
                           i, o.hit_cnt, o.wr_n, o.mod_n, o.age_n, e.hit_cnt, e.wr_n, e.mod_n, e.age_n);
      end
    end
  endtask

  initial begin
    test_reset();
    test_read_hit();
    test_clean_miss();
    test_dirty_write_miss();
    test_fast_mem_ack();
    test_saturation();
    test_reset_during_fill();
    test_relookup_error();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_controller.md
CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 SHALL have parameter TAG_WIDTH, default 8, tag field width.
REQ-002 SHALL have parameter INDEX_WIDTH, default 4, set index width.
REQ-003 SHALL have parameter OFFSET_WIDTH, default 4, line offset width.
REQ-004 SHALL have parameter CHAN_WIDTH, default 3, way number width (8 ways).
REQ-005 SHALL have ports (A = TAG_WIDTH+INDEX_WIDTH+OFFSET_WIDTH):
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- cpu_req  in  1  access request, sampled in IDLE only.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  A  byte address {tag,index,offset}.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_busy  out  1  high whenever state != IDLE.
- tm_tag  out  TAG_WIDTH  lookup/allocate tag to tag memory.
- tm_index  out  INDEX_WIDTH  set index to tag memory.
- tm_wr  out  1  tag write strobe.
- tm_mod  out  1  modified bit for write.
- tm_age  out  1  LRU update strobe.
- tm_hit  in  1  lookup hit.
- tm_chan  in  CHAN_WIDTH  hit way.
- tm_age_chan  in  CHAN_WIDTH  LRU victim way.
- tm_age_tag  in  TAG_WIDTH  victim tag.
- tm_age_mod  in  1  victim dirty.
- line_chan  out  CHAN_WIDTH  way selected for data array.
- mem_req  out  1  backing-memory line request.
- mem_we  out  1  1 = write-back, 0 = fill.
- mem_addr  out  TAG_WIDTH+INDEX_WIDTH  line address.
- mem_ack  in  1  memory completion, one cycle.
- hit_cnt, miss_cnt  out  16 each  saturating statistics.
- err  out  1  sticky protocol error.

Function
REQ-006 SHALL implement FSM IDLE, LOOKUP, HIT_UPD, WB, FILL, ALLOC, DONE.
REQ-007 IDLE: cpu_req=1 SHALL latch cpu_addr, cpu_we, set first-lookup flag, go LOOKUP; cpu_req in any other state SHALL be ignored.
REQ-008 tm_tag/tm_index SHALL always drive latched tag/index fields; offset is not used.
REQ-009 LOOKUP (1 cycle, tag memory combinational): tm_hit -> HIT_UPD, line_chan<=tm_chan; miss and tm_age_mod -> WB, latch victim tag and tm_age_chan; miss and !tm_age_mod -> FILL, latch tm_age_chan.
REQ-010 On the first LOOKUP of a request SHALL increment hit_cnt (hit) or miss_cnt (miss), saturating at 0xFFFF, then clear first-lookup flag.
REQ-011 HIT_UPD (1 cycle): tm_age=1; if latched we, tm_wr=1 and tm_mod=1 same cycle; -> DONE.
REQ-012 WB: mem_req=1, mem_we=1, mem_addr={victim tag,index}, held stable until mem_ack sampled high -> FILL.
REQ-013 FILL: mem_req=1, mem_we=0, mem_addr={tag,index}, line_chan=victim way, held until mem_ack -> ALLOC.
REQ-014 ALLOC (1 cycle): tm_wr=1, tm_mod=0, tm_age=0 -> LOOKUP (re-lookup SHALL hit and proceed via HIT_UPD).
REQ-015 Re-lookup miss after ALLOC SHALL set err=1 (sticky until reset) and go DONE.
REQ-016 DONE: cpu_ack=1 for exactly one cycle -> IDLE.
REQ-017 Latency from accept edge: hit = ack in 3rd cycle; clean miss = 3 + fill wait + 3; dirty miss adds write-back wait.
REQ-018 mem_ack outside WB/FILL SHALL be ignored; mem_ack in the first WB/FILL cycle SHALL be accepted.
REQ-019 tm_wr, tm_age, mem_req, cpu_ack SHALL be 0 in all states not listed as asserting them.

Reset
REQ-020 rst_n=0 at a clock edge SHALL force IDLE, all outputs 0, counters 0, err 0, latched fields 0.
REQ-021 Reset mid-operation SHALL abort: mem_req low the cycle after, no cpu_ack, no tag write.

Verification
REQ-022 Read hit: tm_hit=1, tm_chan=5, addr 0x3A7C -> tm_tag=0x3A, tm_index=0x7, tm_age 1 cycle, tm_wr=0, cpu_ack 3rd cycle, hit_cnt=1.
REQ-023 Clean read miss: tm_hit=0, tm_age_chan=2, tm_age_mod=0 -> mem_req, mem_we=0, mem_addr=0x3A7, line_chan=2; mem_ack after 4 cycles -> tm_wr pulse, re-lookup, tm_age, cpu_ack; miss_cnt=1, hit_cnt=0.
REQ-024 Dirty write miss: tm_age_tag=0x11, tm_age_mod=1 -> mem_we=1 mem_addr=0x117, then fill 0x3A7, ALLOC, HIT_UPD with tm_wr=tm_mod=1.
REQ-025 Saturation: preload 0xFFFF hits, one more hit -> hit_cnt stays 0xFFFF.
REQ-026 Reset during FILL -> next cycle mem_req=0, cpu_busy=0, no cpu_ack; spurious mem_ack in IDLE -> no state change.
REQ-027 Re-lookup forced miss after ALLOC -> err=1, cpu_ack pulses, err persists until rst_n.
